sdram_slot_arbiter: RTL and testbench

//  Front end of the byte-wide SDRAM controller. Arbitrates two requesters, the Z80 CPU port and
//  the video fetch port, onto the controller's single access interface, one access per clkref slot.

---
 rtl/sdram_slot_arbiter.sv | 120 ++++++++++++
 tb/tb_sdram_slot_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_slot_arbiter.sv
// Slot arbiter in front of the byte-wide SDRAM controller: one CPU or video access per clkref slot,
// with forced idle slots so the controller can auto-refresh.
module sdram_slot_arbiter #(
  parameter int unsigned VIDEO_FIRST = 1,
  parameter int unsigned REFRESH_MAX = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clkref,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic        cpu_ack,
  output logic [7:0]  cpu_dout,
  input  logic        vid_req,
  input  logic [24:0] vid_addr,
  output logic        vid_ack,
  output logic [7:0]  vid_dout,
  output logic [24:0] sd_addr,
  output logic        sd_we,
  output logic [7:0]  sd_din,
  output logic        sd_oe,
  input  logic [7:0]  sd_dout
);

  localparam int unsigned RW = $clog2(REFRESH_MAX + 2);
  localparam logic [RW-1:0] RUN_MAX = RW'(REFRESH_MAX);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID} owner_t;

  owner_t        r_owner, w_owner_nxt;
  logic [RW-1:0] r_run, w_run_nxt;
  logic          r_rr_vid, w_rr_vid_nxt;
  logic          r_clkref_d;
  logic          w_slot_start;
  logic          w_cpu_elig, w_vid_elig, w_vid_wins;
  logic [24:0]   w_addr_nxt;
  logic [7:0]    w_din_nxt;
  logic          w_we_nxt, w_oe_nxt;

  assign w_slot_start = clkref & ~r_clkref_d;

  // The port owning the finishing slot still shows req high on its ack edge, so it sits this one out.
  assign w_cpu_elig = cpu_req & (r_owner != OWN_CPU);
  assign w_vid_elig = vid_req & (r_owner != OWN_VID);
  assign w_vid_wins = w_vid_elig & (~w_cpu_elig | (VIDEO_FIRST != 0) | r_rr_vid);

  always_comb begin
    w_owner_nxt  = r_owner;
    w_run_nxt    = r_run;
    w_rr_vid_nxt = r_rr_vid;
    w_addr_nxt   = sd_addr;
    w_din_nxt    = sd_din;
    w_we_nxt     = sd_we;
    w_oe_nxt     = sd_oe;
    if ((r_run == RUN_MAX) || !(w_cpu_elig || w_vid_elig)) begin
      w_owner_nxt = OWN_NONE;
      w_oe_nxt    = 1'b0;
      w_we_nxt    = 1'b0;
      w_run_nxt   = '0;
    end else begin
      w_run_nxt = (r_run == RUN_MAX) ? RUN_MAX : r_run + 1'b1;
      if (w_vid_wins) begin
        w_owner_nxt = OWN_VID;
        w_addr_nxt  = vid_addr;
        w_oe_nxt    = 1'b1;
        w_we_nxt    = 1'b0;
      end else begin
        w_owner_nxt = OWN_CPU;
        w_addr_nxt  = cpu_addr;
        w_din_nxt   = cpu_din;
        w_oe_nxt    = ~cpu_we;
        w_we_nxt    = cpu_we;
      end
      if (VIDEO_FIRST == 0) begin
        w_rr_vid_nxt = ~w_vid_wins;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clkref_d <= 1'b0;
      r_owner    <= OWN_NONE;
      r_run      <= '0;
      r_rr_vid   <= 1'b0;
      cpu_ack    <= 1'b0;
      vid_ack    <= 1'b0;
      cpu_dout   <= '0;
      vid_dout   <= '0;
      sd_addr    <= '0;
      sd_din     <= '0;
      sd_we      <= 1'b0;
      sd_oe      <= 1'b0;
    end else begin
      r_clkref_d <= clkref;
      cpu_ack    <= 1'b0;
      vid_ack    <= 1'b0;
      if (w_slot_start) begin
        if (r_owner == OWN_CPU) begin
          cpu_ack <= 1'b1;
          if (!sd_we) cpu_dout <= sd_dout;
        end
        if (r_owner == OWN_VID) begin
          vid_ack  <= 1'b1;
          vid_dout <= sd_dout;
        end
        r_owner  <= w_owner_nxt;
        r_run    <= w_run_nxt;
        r_rr_vid <= w_rr_vid_nxt;
        sd_addr  <= w_addr_nxt;
        sd_din   <= w_din_nxt;
        sd_we    <= w_we_nxt;
        sd_oe    <= w_oe_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: DUT 0 uses video priority, DUT 1 round-robin; both checked per slot
// against a slot-level reference model of the arbitration rules.
module tb_sdram_slot_arbiter;

  localparam int RMAX     = 7;
  localparam int WAIT_MAX = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clkref;
  logic        cpu_req[2], cpu_we[2], vid_req[2];
  logic [24:0] cpu_addr[2], vid_addr[2];
  logic [7:0]  cpu_din[2], sd_dout[2];
  logic        cpu_ack[2], vid_ack[2], sd_we[2], sd_oe[2];
  logic [7:0]  cpu_dout[2], vid_dout[2], sd_din[2];
  logic [24:0] sd_addr[2];

  sdram_slot_arbiter #(.VIDEO_FIRST(1), .REFRESH_MAX(RMAX)) u_dut_vf (
    .clk(clk), .reset_n(reset_n), .clkref(clkref),
    .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_din(cpu_din[0]),
    .cpu_ack(cpu_ack[0]), .cpu_dout(cpu_dout[0]),
    .vid_req(vid_req[0]), .vid_addr(vid_addr[0]), .vid_ack(vid_ack[0]), .vid_dout(vid_dout[0]),
    .sd_addr(sd_addr[0]), .sd_we(sd_we[0]), .sd_din(sd_din[0]), .sd_oe(sd_oe[0]), .sd_dout(sd_dout[0])
  );

  sdram_slot_arbiter #(.VIDEO_FIRST(0), .REFRESH_MAX(RMAX)) u_dut_rr (
    .clk(clk), .reset_n(reset_n), .clkref(clkref),
    .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_din(cpu_din[1]),
    .cpu_ack(cpu_ack[1]), .cpu_dout(cpu_dout[1]),
    .vid_req(vid_req[1]), .vid_addr(vid_addr[1]), .vid_ack(vid_ack[1]), .vid_dout(vid_dout[1]),
    .sd_addr(sd_addr[1]), .sd_we(sd_we[1]), .sd_din(sd_din[1]), .sd_oe(sd_oe[1]), .sd_dout(sd_dout[1])
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: owner 0=none 1=cpu 2=video, rr 0=cpu preferred 1=video preferred.
  int          m_owner[2], m_run[2], m_rr[2];
  bit          m_oe[2], m_we[2], e_cack[2], e_vack[2];
  logic [24:0] m_addr[2];
  logic [7:0]  m_din[2], m_cdout[2], m_vdout[2];

  logic [52:0] snap[2];
  int          cw[2], vw[2];
  bit          rand_mode = 0;
  bit          fdout_en  = 0;
  logic [7:0]  fdout;

  function automatic logic [52:0] obs_vec(input int i);
    return {cpu_ack[i], vid_ack[i], sd_oe[i], sd_we[i], sd_addr[i], sd_din[i], cpu_dout[i], vid_dout[i]};
  endfunction

  function automatic logic [52:0] exp_vec(input int i, input bit with_acks);
    return {with_acks & e_cack[i], with_acks & e_vack[i], m_oe[i], m_we[i], m_addr[i], m_din[i],
            m_cdout[i], m_vdout[i]};
  endfunction

  function automatic byte obs_grant(input int i);
    if (!snap[i][50] && !snap[i][49]) return "N";
    if (snap[i][48:24] == vid_addr[i]) return "V";
    return "C";
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_owner[i] = 0; m_run[i] = 0; m_rr[i] = 0; m_oe[i] = 0; m_we[i] = 0;
      e_cack[i] = 0; e_vack[i] = 0; m_addr[i] = '0; m_din[i] = '0; m_cdout[i] = '0; m_vdout[i] = '0;
    end
  endtask

  task automatic model_slot(input int i);
    bit ce, ve, vwin, vf;
    vf = (i == 0);
    e_cack[i] = (m_owner[i] == 1);
    e_vack[i] = (m_owner[i] == 2);
    if (e_cack[i] && !m_we[i]) m_cdout[i] = sd_dout[i];
    if (e_vack[i]) m_vdout[i] = sd_dout[i];
    ce = cpu_req[i] && (m_owner[i] != 1);
    ve = vid_req[i] && (m_owner[i] != 2);
    if (m_run[i] == RMAX || !(ce || ve)) begin
      m_owner[i] = 0; m_oe[i] = 0; m_we[i] = 0; m_run[i] = 0;
    end else begin
      vwin = (ce && ve) ? (vf || m_rr[i] == 1) : ve;
      m_run[i] = (m_run[i] + 1 > RMAX) ? RMAX : m_run[i] + 1;
      if (vwin) begin
        m_owner[i] = 2; m_addr[i] = vid_addr[i]; m_oe[i] = 1; m_we[i] = 0;
      end else begin
        m_owner[i] = 1; m_addr[i] = cpu_addr[i]; m_din[i] = cpu_din[i];
        m_oe[i] = !cpu_we[i]; m_we[i] = cpu_we[i];
      end
      if (!vf) m_rr[i] = vwin ? 0 : 1;
    end
  endtask

  task automatic drive_requesters();
    for (int i = 0; i < 2; i++) begin
      if (cw[i] >= 0) begin
        cw[i]++;
        if (snap[i][52] || cw[i] > WAIT_MAX) begin
          checks++;
          if (!snap[i][52] || cw[i] > WAIT_MAX) begin
            failures++;
            $display("FAIL cpu_wait dut%0d waited=%0d slots limit=%0d", i, cw[i], WAIT_MAX);
          end
          cw[i] = -1; cpu_req[i] = 0;
        end
      end
      if (vw[i] >= 0) begin
        vw[i]++;
        if (snap[i][51] || vw[i] > WAIT_MAX) begin
          checks++;
          if (!snap[i][51] || vw[i] > WAIT_MAX) begin
            failures++;
            $display("FAIL vid_wait dut%0d waited=%0d slots limit=%0d", i, vw[i], WAIT_MAX);
          end
          vw[i] = -1; vid_req[i] = 0;
        end
      end
      if (cw[i] < 0 && $urandom_range(0, 2) != 0) begin
        cpu_req[i] = 1; cpu_we[i] = 1'($urandom_range(0, 1));
        cpu_addr[i] = 25'($urandom); cpu_din[i] = 8'($urandom); cw[i] = 0;
      end
      if (vw[i] < 0 && $urandom_range(0, 2) != 0) begin
        vid_req[i] = 1; vid_addr[i] = 25'($urandom); vw[i] = 0;
      end
    end
  endtask

  // One 16-clk slot: clkref rises at c=0, the slot edge lands before c=1; optional reset at reset_at.
  task automatic run_slot(input int reset_at);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) clkref = 1;
      if (c == 8) clkref = 0;
      if (c == 1) begin
        for (int i = 0; i < 2; i++) begin
          model_slot(i);
          snap[i] = obs_vec(i);
          checks++;
          if (snap[i] !== exp_vec(i, 1'b1)) begin
            failures++;
            $display("FAIL slot_edge dut%0d got=%h exp=%h", i, snap[i], exp_vec(i, 1'b1));
          end
        end
        if (rand_mode) drive_requesters();
        for (int i = 0; i < 2; i++) sd_dout[i] = fdout_en ? fdout : 8'($urandom);
      end
      if (c == 9) begin
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (obs_vec(i) !== exp_vec(i, 1'b0)) begin
            failures++;
            $display("FAIL mid_slot_hold dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i, 1'b0));
          end
        end
      end
      if (reset_at >= 0 && c == reset_at) begin
        reset_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
          checks++;
          if (obs_vec(i) !== 53'd0) begin
            failures++;
            $display("FAIL async_reset dut%0d got=%h exp=0", i, obs_vec(i));
          end
        end
        model_reset();
      end
      if (reset_at >= 0 && c == reset_at + 2) reset_n = 1;
    end
  endtask

  task automatic do_reset();
    reset_n = 0; clkref = 0; fdout_en = 0; fdout = '0;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 0; cpu_we[i] = 0; cpu_addr[i] = '0; cpu_din[i] = '0;
      vid_req[i] = 0; vid_addr[i] = '0; sd_dout[i] = '0; cw[i] = -1; vw[i] = -1;
    end
    repeat (3) @(negedge clk);
    model_reset();
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1; clkref = 0;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 1; vid_req[i] = 1; cpu_addr[i] = 25'h1555555; sd_dout[i] = 8'hFF;
    end
    @(negedge clk);
    reset_n = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_vec(i) !== 53'd0) begin
        failures++;
        $display("FAIL reset_state dut%0d got=%h exp=0", i, obs_vec(i));
      end
    end
    do_reset();
  endtask

  task automatic test_cpu_read_write();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 1; cpu_we[i] = 0; cpu_addr[i] = 25'h0000123; cpu_din[i] = 8'h11;
    end
    fdout_en = 1; fdout = 8'h5A;
    run_slot(-1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (snap[i][50:49] !== 2'b10 || snap[i][48:24] !== 25'h0000123) begin
        failures++;
        $display("FAIL read_grant dut%0d oe_we=%b addr=%h exp oe_we=10 addr=0000123", i, snap[i][50:49], snap[i][48:24]);
      end
    end
    run_slot(-1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (snap[i][52] !== 1'b1 || snap[i][15:8] !== 8'h5A || snap[i][50] !== 1'b0) begin
        failures++;
        $display("FAIL read_ack dut%0d ack=%b dout=%h oe=%b exp ack=1 dout=5a oe=0", i, snap[i][52], snap[i][15:8], snap[i][50]);
      end
      cpu_req[i] = 1; cpu_we[i] = 1; cpu_addr[i] = 25'h1FFFFFF; cpu_din[i] = 8'hC3;
    end
    fdout = 8'hA5;
    run_slot(-1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (snap[i][50:49] !== 2'b01 || snap[i][23:16] !== 8'hC3 || snap[i][48:24] !== 25'h1FFFFFF) begin
        failures++;
        $display("FAIL write_grant dut%0d oe_we=%b din=%h addr=%h exp 01 c3 1ffffff", i, snap[i][50:49], snap[i][23:16], snap[i][48:24]);
      end
    end
    run_slot(-1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (snap[i][52] !== 1'b1 || snap[i][15:8] !== 8'h5A) begin
        failures++;
        $display("FAIL write_ack dut%0d ack=%b dout=%h exp ack=1 dout=5a", i, snap[i][52], snap[i][15:8]);
      end
      cpu_req[i] = 0;
    end
    fdout_en = 0;
  endtask

  task automatic test_both_requesting();
    string p_vf, p_rr;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 1; cpu_we[i] = 0; cpu_addr[i] = 25'h0000100;
      vid_req[i] = 1; vid_addr[i] = 25'h00ABCDE;
    end
    p_vf = "VCVCVCVN";
    for (int s = 0; s < 16; s++) begin
      run_slot(-1);
      p_rr = (s < 8) ? "CVCVCVCN" : "VCVCVCVN";
      checks++;
      if (obs_grant(0) !== p_vf[s % 8]) begin
        failures++;
        $display("FAIL grant_order_vf slot%0d got=%c exp=%c", s, obs_grant(0), p_vf[s % 8]);
      end
      checks++;
      if (obs_grant(1) !== p_rr[s % 8]) begin
        failures++;
        $display("FAIL grant_order_rr slot%0d got=%c exp=%c", s, obs_grant(1), p_rr[s % 8]);
      end
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (snap[i][52] && snap[i][51]) begin
          failures++;
          $display("FAIL ack_overlap dut%0d slot%0d cpu_ack=1 vid_ack=1 exp at most one", i, s);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 0; vid_req[i] = 0;
    end
  endtask

  task automatic test_reset_mid_slot();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      vid_req[i] = 1; vid_addr[i] = 25'h00000F0;
    end
    run_slot(-1);
    run_slot(10);
    run_slot(-1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (snap[i][51] !== 1'b0 || obs_grant(i) !== "V") begin
        failures++;
        $display("FAIL post_reset_grant dut%0d vid_ack=%b grant=%c exp vid_ack=0 grant=V", i, snap[i][51], obs_grant(i));
      end
      vid_req[i] = 0;
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 1; cpu_we[i] = 0; cpu_addr[i] = 25'h0ACE000;
    end
    for (int s = 0; s < 20; s++) begin
      run_slot(-1);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs_grant(i) !== ((s % 2 == 0) ? "C" : "N")) begin
          failures++;
          $display("FAIL single_req dut%0d slot%0d got=%c exp=%c", i, s, obs_grant(i), (s % 2 == 0) ? "C" : "N");
        end
      end
    end
  endtask

  task automatic test_clkref_stuck();
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 1; vid_req[i] = 1; cpu_addr[i] = 25'h0123456; vid_addr[i] = 25'h0654321;
      sd_dout[i] = 8'h77;
    end
    repeat (40) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_vec(i) !== exp_vec(i, 1'b0)) begin
        failures++;
        $display("FAIL clkref_stuck dut%0d got=%h exp=%h", i, obs_vec(i), exp_vec(i, 1'b0));
      end
      cpu_req[i] = 0; vid_req[i] = 0;
    end
  endtask

  task automatic test_random();
    do_reset();
    rand_mode = 1;
    for (int s = 0; s < 200; s++) run_slot(-1);
    rand_mode = 0;
  endtask

  initial begin
    test_reset();
    test_cpu_read_write();
    test_both_requesting();
    test_reset_mid_slot();
    test_single_requester();
    test_clkref_stuck();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
